// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: accepts one (A, B, opcode) command, replays it to the
// 8-bit calculator as load_a -> load_b -> load_opcode -> execute, waits
// RESULT_LAT cycles, then returns result and zero flag on a response port.
module calc_cmd_sequencer #(
   parameter int RESULT_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   input  logic [2:0] cmd_op,
   output logic [7:0] calc_input,
   output logic       calc_load_a,
   output logic       calc_load_b,
   output logic [2:0] calc_opcode,
   output logic       calc_load_opcode,
   output logic       calc_execute,
   input  logic [7:0] calc_result,
   input  logic       calc_zero,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_result,
   output logic       rsp_zero,
   output logic [2:0] rsp_op,
   output logic       busy,
   output logic [7:0] done_count
);

   // The wait counter is 4 bits wide, so only 1..15 is meaningful.
   if ((RESULT_LAT < 1) || (RESULT_LAT > 15)) begin : g_bad_result_lat
      $error("calc_cmd_sequencer: RESULT_LAT must be within 1..15");
   end

   localparam logic [3:0] LP_LAT = 4'(RESULT_LAT);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_A  = 3'd1,
      S_LOAD_B  = 3'd2,
      S_LOAD_OP = 3'd3,
      S_EXEC    = 3'd4,
      S_WAIT    = 3'd5,
      S_RESP    = 3'd6
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       r_run_en;      // low during reset and the first edge after it
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [2:0] r_op;
   logic [3:0] r_cnt;
   logic       r_load_a;
   logic       r_load_b;
   logic       r_load_op;
   logic       r_exec;
   logic [7:0] r_input;
   logic       r_rsp_valid;
   logic [7:0] r_rsp_result;
   logic       r_rsp_zero;
   logic [7:0] r_done;
   logic       w_cmd_ready;
   logic       w_cmd_fire;
   logic       w_wait_done;
   logic [7:0] w_input_nxt;

   assign w_cmd_ready = (r_state == S_IDLE) && r_run_en;
   assign w_cmd_fire  = cmd_valid && w_cmd_ready;
   assign w_wait_done = (r_state == S_WAIT) && (r_cnt == 4'd1);

   // Next-state decode for the fixed strobe sequence.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_cmd_fire) begin
               w_next = S_LOAD_A;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_LOAD_A:  w_next = S_LOAD_B;
         S_LOAD_B:  w_next = S_LOAD_OP;
         S_LOAD_OP: w_next = S_EXEC;
         S_EXEC:    w_next = S_WAIT;
         S_WAIT: begin
            if (w_wait_done) begin
               w_next = S_RESP;
            end else begin
               w_next = S_WAIT;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_next = S_IDLE;
            end else begin
               w_next = S_RESP;
            end
         end
         default:   w_next = S_IDLE;
      endcase
   end

   // Data bus value for the coming cycle: A is taken straight from the
   // command port because it is captured on the same edge.
   always_comb begin
      w_input_nxt = 8'd0;
      case (w_next)
         S_LOAD_A: w_input_nxt = cmd_a;
         S_LOAD_B: w_input_nxt = r_b;
         default:  w_input_nxt = 8'd0;
      endcase
   end

   // State register, command capture, registered strobes and response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_run_en     <= 1'b0;
         r_a          <= 8'd0;
         r_b          <= 8'd0;
         r_op         <= 3'd0;
         r_cnt        <= 4'd0;
         r_load_a     <= 1'b0;
         r_load_b     <= 1'b0;
         r_load_op    <= 1'b0;
         r_exec       <= 1'b0;
         r_input      <= 8'd0;
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= 8'd0;
         r_rsp_zero   <= 1'b0;
         r_done       <= 8'd0;
      end else begin
         r_state   <= w_next;
         r_run_en  <= 1'b1;
         r_load_a  <= (w_next == S_LOAD_A);
         r_load_b  <= (w_next == S_LOAD_B);
         r_load_op <= (w_next == S_LOAD_OP);
         r_exec    <= (w_next == S_EXEC);
         r_input   <= w_input_nxt;
         if (w_cmd_fire) begin
            r_a  <= cmd_a;
            r_b  <= cmd_b;
            r_op <= cmd_op;
         end
         if (r_state == S_EXEC) begin
            r_cnt <= LP_LAT;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_wait_done) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= calc_result;
            r_rsp_zero   <= calc_zero;
         end else if ((r_state == S_RESP) && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_done      <= r_done + 8'd1;
         end
      end
   end

   assign cmd_ready        = w_cmd_ready;
   assign calc_input       = r_input;
   assign calc_load_a      = r_load_a;
   assign calc_load_b      = r_load_b;
   assign calc_opcode      = r_op;
   assign calc_load_opcode = r_load_op;
   assign calc_execute     = r_exec;
   assign rsp_valid        = r_rsp_valid;
   assign rsp_result       = r_rsp_result;
   assign rsp_zero         = r_rsp_zero;
   assign rsp_op           = r_op;
   assign busy             = (r_state != S_IDLE);
   assign done_count       = r_done;

endmodule
